// File: rtl/alct_phase_pkg.sv
// Shared definitions for the ALCT receive-phase calibration controller.
package alct_phase_pkg;

    localparam int unsigned NdlyDefault   = 16;
    localparam int unsigned SettleDefault = 8;
    localparam int unsigned NcmpDefault   = 256;

    typedef enum logic [3:0] {
        StIdle,
        StSet,
        StWaitB,
        StSettle,
        StCmp,
        StRec,
        StEval,
        StApply,
        StWaitA,
        StDone
    } state_e;

    function automatic int unsigned dly_width(input int unsigned ndly);
        return (ndly > 1) ? $clog2(ndly) : 1;
    endfunction

endpackage

// File: rtl/alct_run_finder.sv
// Serial longest-run-of-ones finder; runs restart at each segment boundary.
module alct_run_finder
    import alct_phase_pkg::*;
#(
    parameter int unsigned DW = dly_width(NdlyDefault),
    localparam int unsigned LW = DW + 1
) (
    input  logic          clock,
    input  logic          clr,
    input  logic          init_i,
    input  logic          valid_i,
    input  logic          bit_i,
    input  logic          seg_start_i,
    input  logic          seg_i,
    input  logic [DW-1:0] idx_i,
    output logic [DW-1:0] best_start_o,
    output logic [LW-1:0] best_len_o,
    output logic          best_seg_o
);

    logic [DW-1:0] cur_start_q, cur_start_d, best_start_q, best_start_d;
    logic [LW-1:0] cur_len_q, cur_len_d, best_len_q, best_len_d, run_len;
    logic          best_seg_q, best_seg_d;

    always_comb begin
        cur_start_d  = cur_start_q;
        cur_len_d    = cur_len_q;
        best_start_d = best_start_q;
        best_len_d   = best_len_q;
        best_seg_d   = best_seg_q;
        run_len      = seg_start_i ? '0 : cur_len_q;
        if (init_i) begin
            cur_start_d  = '0;
            cur_len_d    = '0;
            best_start_d = '0;
            best_len_d   = '0;
            best_seg_d   = 1'b0;
        end else if (valid_i) begin
            if (bit_i) begin
                cur_len_d   = run_len + LW'(1);
                cur_start_d = (run_len == '0) ? idx_i : cur_start_q;
                // Strictly longer only: equal runs keep the earlier one (posneg 0).
                if (cur_len_d > best_len_q) begin
                    best_len_d   = cur_len_d;
                    best_start_d = cur_start_d;
                    best_seg_d   = seg_i;
                end
            end else begin
                cur_len_d = '0;
            end
        end
    end

    always_ff @(posedge clock or posedge clr) begin
        if (clr) begin
            cur_start_q  <= '0;
            cur_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
            best_seg_q   <= 1'b0;
        end else begin
            cur_start_q  <= cur_start_d;
            cur_len_q    <= cur_len_d;
            best_start_q <= best_start_d;
            best_len_q   <= best_len_d;
            best_seg_q   <= best_seg_d;
        end
    end

    assign best_start_o = best_start_q;
    assign best_len_o   = best_len_q;
    assign best_seg_o   = best_seg_q;

endmodule

// File: rtl/alct_rx_phase_scan.sv
// Sweeps posneg x delay tap against a known pattern, then programs the centre
// of the longest passing window back into the demux and delay chain.
module alct_rx_phase_scan
    import alct_phase_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned NDLY   = NdlyDefault,
    parameter int unsigned SETTLE = SettleDefault,
    parameter int unsigned NCMP   = NcmpDefault,
    localparam int unsigned DW    = dly_width(NDLY)
) (
    input  logic              clock,
    input  logic              clr,
    input  logic              start,
    input  logic [WIDTH-1:0]  dout1st,
    input  logic [WIDTH-1:0]  dout2nd,
    input  logic [WIDTH-1:0]  exp1st,
    input  logic [WIDTH-1:0]  exp2nd,
    input  logic              dly_busy,
    output logic [DW-1:0]     dly_val,
    output logic              dly_wr,
    output logic              posneg,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic [2*NDLY-1:0] pass_map,
    output logic              best_posneg,
    output logic [DW-1:0]     best_dly
);

    localparam int unsigned LW = DW + 1;
    localparam int unsigned CW = $clog2(NCMP + SETTLE + 2 * NDLY + 1);
    localparam logic [CW-1:0] SettleLast = CW'(SETTLE - 1);
    localparam logic [CW-1:0] CmpLast    = CW'(NCMP - 1);
    localparam logic [CW-1:0] EvalLast   = CW'(2 * NDLY - 1);
    localparam logic [DW-1:0] TapLast    = DW'(NDLY - 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DW-1:0]     tap_q, tap_d, dly_val_q, dly_val_d, best_dly_q, best_dly_d;
    logic              posneg_q, posneg_d, err_q, err_d, busy_q, busy_d;
    logic              done_q, done_d, found_q, found_d, best_pn_q, best_pn_d;
    logic [2*NDLY-1:0] map_q, map_d;

    logic              fnd_init, fnd_seg, mismatch;
    logic [DW-1:0]     fnd_start, half_len, cand_dly;
    logic [LW-1:0]     fnd_len;
    logic              cand_found, cand_pn;
    logic [LW-1:0]     eval_idx;

    assign mismatch   = |{dout1st ^ exp1st, dout2nd ^ exp2nd};
    assign eval_idx   = cnt_q[LW-1:0];
    assign cand_found = (fnd_len != '0);
    assign half_len   = DW'((fnd_len - LW'(1)) >> 1);
    assign cand_dly   = cand_found ? fnd_start + half_len : '0;
    assign cand_pn    = cand_found & fnd_seg;

    alct_run_finder #(
        .DW (DW)
    ) u_run_finder (
        .clock        (clock),
        .clr          (clr),
        .init_i       (fnd_init),
        .valid_i      (state_q == StEval),
        .bit_i        (map_q[eval_idx]),
        .seg_start_i  (eval_idx[DW-1:0] == '0),
        .seg_i        (eval_idx[DW]),
        .idx_i        (eval_idx[DW-1:0]),
        .best_start_o (fnd_start),
        .best_len_o   (fnd_len),
        .best_seg_o   (fnd_seg)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tap_d      = tap_q;
        posneg_d   = posneg_q;
        err_d      = err_q;
        busy_d     = busy_q;
        done_d     = done_q;
        found_d    = found_q;
        best_pn_d  = best_pn_q;
        best_dly_d = best_dly_q;
        map_d      = map_q;
        dly_val_d  = dly_val_q;
        fnd_init   = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d    = StSet;
                    cnt_d      = '0;
                    tap_d      = '0;
                    posneg_d   = 1'b0;
                    err_d      = 1'b0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    found_d    = 1'b0;
                    best_pn_d  = 1'b0;
                    best_dly_d = '0;
                    map_d      = '0;
                    dly_val_d  = '0;
                    fnd_init   = 1'b1;
                end
            end
            StSet: begin
                state_d = StWaitB;
                cnt_d   = '0;
            end
            StWaitB, StWaitA: begin
                // The programmer may not raise busy until after our write lands.
                if (cnt_q == '0) begin
                    cnt_d = CW'(1);
                end else if (!dly_busy) begin
                    cnt_d = '0;
                    if (state_q == StWaitB) begin
                        state_d = StSettle;
                    end else begin
                        state_d = StDone;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            StSettle: begin
                if (cnt_q == SettleLast) begin
                    state_d = StCmp;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StCmp: begin
                err_d = err_q | mismatch;
                if (cnt_q == CmpLast) begin
                    state_d = StRec;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StRec: begin
                map_d[{posneg_q, tap_q}] = ~err_q;
                err_d = 1'b0;
                cnt_d = '0;
                if (tap_q != TapLast) begin
                    tap_d     = tap_q + DW'(1);
                    dly_val_d = tap_q + DW'(1);
                    state_d   = StSet;
                end else if (!posneg_q) begin
                    posneg_d  = 1'b1;
                    tap_d     = '0;
                    dly_val_d = '0;
                    state_d   = StSet;
                end else begin
                    state_d = StEval;
                end
            end
            StEval: begin
                if (cnt_q == EvalLast) begin
                    state_d = StApply;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StApply: begin
                posneg_d   = cand_pn;
                dly_val_d  = cand_dly;
                found_d    = cand_found;
                best_pn_d  = cand_pn;
                best_dly_d = cand_dly;
                state_d    = StWaitA;
                cnt_d      = '0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge clr) begin
        if (clr) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            tap_q      <= '0;
            posneg_q   <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            found_q    <= 1'b0;
            best_pn_q  <= 1'b0;
            best_dly_q <= '0;
            map_q      <= '0;
            dly_val_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tap_q      <= tap_d;
            posneg_q   <= posneg_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            found_q    <= found_d;
            best_pn_q  <= best_pn_d;
            best_dly_q <= best_dly_d;
            map_q      <= map_d;
            dly_val_q  <= dly_val_d;
        end
    end

    // APPLY drives the evaluator result directly so the write lands in that cycle.
    assign dly_wr      = (state_q == StSet) || (state_q == StApply);
    assign dly_val     = (state_q == StApply) ? cand_dly : dly_val_q;
    assign posneg      = (state_q == StApply) ? cand_pn : posneg_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign found       = found_q;
    assign pass_map    = map_q;
    assign best_posneg = best_pn_q;
    assign best_dly    = best_dly_q;

endmodule

// File: tb/tb_alct_rx_phase_scan.sv
// Directed bench: a demux model that matches the pattern only on selected settings.
module tb_alct_rx_phase_scan;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned NDLY  = 16;
    localparam int unsigned DW    = 4;
    // Busy-high cycles of one scan (the start-sampling cycle is not counted).
    localparam int ScanCycles = 2 * 16 * (1 + 2 + 8 + 256 + 1) + 32 + 1 + 2;
    localparam int Limit      = 20000;

    logic              clock = 1'b0;
    logic              clr = 1'b1, start = 1'b0, dly_busy = 1'b0, inj = 1'b0;
    logic [WIDTH-1:0]  dout1st, dout2nd;
    logic [WIDTH-1:0]  exp1st = 16'hA5C3, exp2nd = 16'h3C5A;
    logic [DW-1:0]     dly_val, best_dly, cur_tap;
    logic              dly_wr, posneg, busy, done, found, best_posneg, ok;
    logic [2*NDLY-1:0] pass_map;
    logic [2*NDLY-1:0] good_mask = '0;
    int                checks = 0, errors = 0;

    always #5 clock = ~clock;

    alct_rx_phase_scan #(
        .WIDTH  (WIDTH),
        .NDLY   (NDLY),
        .SETTLE (8),
        .NCMP   (256)
    ) dut (
        .clock       (clock),
        .clr         (clr),
        .start       (start),
        .dout1st     (dout1st),
        .dout2nd     (dout2nd),
        .exp1st      (exp1st),
        .exp2nd      (exp2nd),
        .dly_busy    (dly_busy),
        .dly_val     (dly_val),
        .dly_wr      (dly_wr),
        .posneg      (posneg),
        .busy        (busy),
        .done        (done),
        .found       (found),
        .pass_map    (pass_map),
        .best_posneg (best_posneg),
        .best_dly    (best_dly)
    );

    // Delay-chain and demux model.
    always @(posedge clock or posedge clr) begin
        if (clr) cur_tap <= '0;
        else if (dly_wr) cur_tap <= dly_val;
    end

    always_comb begin
        ok      = good_mask[{posneg, cur_tap}];
        dout1st = (ok ? exp1st : ~exp1st) ^ {{(WIDTH - 1){1'b0}}, inj};
        dout2nd = ok ? exp2nd : ~exp2nd;
    end

    task automatic do_scan(output int cyc);
        cyc = 0;
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
        checks++;
        if ({busy, done} !== 2'b10) begin
            errors++;
            $display("FAIL scan_start: busy,done got %b required 10", {busy, done});
        end
        for (int i = 0; i < Limit; i++) begin
            if (done) break;
            if (busy) cyc++;
            @(negedge clock);
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL scan_timeout: done got %b required 1", done);
        end
    endtask

    task automatic wait_wr(input logic [DW-1:0] tap, input logic pn, output bit hit);
        hit = 1'b0;
        for (int i = 0; i < Limit; i++) begin
            @(negedge clock);
            if (dly_wr && dly_val == tap && posneg == pn) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL wait_wr: write of tap %0d posneg %0d not seen, required seen", tap, pn);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        checks++;
        if ({busy, done, found, dly_wr, posneg, best_posneg} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b required 000000",
                     {busy, done, found, dly_wr, posneg, best_posneg});
        end
        checks++;
        if ({dly_val, best_dly} !== 8'h00) begin
            errors++;
            $display("FAIL reset_vals: got %h required 00", {dly_val, best_dly});
        end
        checks++;
        if (pass_map !== 32'h0) begin
            errors++;
            $display("FAIL reset_map: got %h required 00000000", pass_map);
        end
        clr = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if ({busy, dly_wr} !== 2'b00) begin
            errors++;
            $display("FAIL idle_hold: busy,dly_wr got %b required 00", {busy, dly_wr});
        end
    endtask

    task automatic test_all_pass();
        int cyc;
        good_mask = 32'hFFFF_FFFF;
        do_scan(cyc);
        checks++;
        if (cyc !== ScanCycles) begin
            errors++;
            $display("FAIL all_cycles: got %0d required %0d", cyc, ScanCycles);
        end
        checks++;
        if (pass_map !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL all_map: got %h required ffffffff", pass_map);
        end
        checks++;
        if ({found, best_posneg, best_dly} !== {1'b1, 1'b0, 4'd7}) begin
            errors++;
            $display("FAIL all_best: got %b required 1_0_0111", {found, best_posneg, best_dly});
        end
        checks++;
        if ({busy, done, posneg, cur_tap} !== {1'b0, 1'b1, 1'b0, 4'd7}) begin
            errors++;
            $display("FAIL all_applied: busy,done,posneg,tap got %b required 0_1_0_0111",
                     {busy, done, posneg, cur_tap});
        end
    endtask

    task automatic test_posneg1_window();
        int cyc;
        exp1st    = 16'h1234;
        exp2nd    = 16'hFEDC;
        good_mask = 32'h07F8_0000;
        do_scan(cyc);
        checks++;
        if (pass_map !== 32'h07F8_0000) begin
            errors++;
            $display("FAIL pn1_map: got %h required 07f80000", pass_map);
        end
        checks++;
        if ({found, best_posneg, best_dly} !== {1'b1, 1'b1, 4'd6}) begin
            errors++;
            $display("FAIL pn1_best: got %b required 1_1_0110", {found, best_posneg, best_dly});
        end
        checks++;
        if ({posneg, cur_tap} !== {1'b1, 4'd6}) begin
            errors++;
            $display("FAIL pn1_applied: got %b required 1_0110", {posneg, cur_tap});
        end
    endtask

    task automatic test_tie();
        int cyc;
        good_mask = 32'h1E00_003C;
        do_scan(cyc);
        checks++;
        if (pass_map !== 32'h1E00_003C) begin
            errors++;
            $display("FAIL tie_map: got %h required 1e00003c", pass_map);
        end
        checks++;
        if ({found, best_posneg, best_dly} !== {1'b1, 1'b0, 4'd3}) begin
            errors++;
            $display("FAIL tie_best: got %b required 1_0_0011", {found, best_posneg, best_dly});
        end
    endtask

    task automatic test_no_match();
        int cyc;
        good_mask = 32'h0;
        do_scan(cyc);
        checks++;
        if (pass_map !== 32'h0) begin
            errors++;
            $display("FAIL none_map: got %h required 00000000", pass_map);
        end
        checks++;
        if ({found, best_posneg, best_dly, done} !== {1'b0, 1'b0, 4'd0, 1'b1}) begin
            errors++;
            $display("FAIL none_best: found,pn,dly,done got %b required 0_0_0000_1",
                     {found, best_posneg, best_dly, done});
        end
        checks++;
        if ({posneg, cur_tap} !== 5'b0) begin
            errors++;
            $display("FAIL none_applied: got %b required 0_0000", {posneg, cur_tap});
        end
    endtask

    task automatic test_single_error_and_busy();
        int cyc;
        bit hit_err, hit_busy;
        exp1st    = 16'hA5C3;
        exp2nd    = 16'h3C5A;
        good_mask = 32'hFFFF_FFFF;
        fork
            do_scan(cyc);
            begin
                wait_wr(4'd4, 1'b0, hit_err);
                if (hit_err) begin
                    repeat (100) @(negedge clock);
                    inj = 1'b1;
                    @(negedge clock) inj = 1'b0;
                end
            end
            begin
                // Busy from the second WAITB cycle for 20 cycles.
                wait_wr(4'd7, 1'b1, hit_busy);
                if (hit_busy) begin
                    repeat (2) @(posedge clock);
                    #1 dly_busy = 1'b1;
                    repeat (20) @(posedge clock);
                    #1 dly_busy = 1'b0;
                end
            end
        join
        checks++;
        if (pass_map !== 32'hFFFF_FFEF) begin
            errors++;
            $display("FAIL err_map: got %h required ffffffef", pass_map);
        end
        checks++;
        if ({found, best_posneg, best_dly} !== {1'b1, 1'b1, 4'd7}) begin
            errors++;
            $display("FAIL err_best: got %b required 1_1_0111", {found, best_posneg, best_dly});
        end
        checks++;
        if (cyc !== ScanCycles + 20) begin
            errors++;
            $display("FAIL busy_extend: got %0d cycles required %0d", cyc, ScanCycles + 20);
        end
    endtask

    task automatic test_clr_mid_scan();
        int cyc;
        bit hit;
        bit first_seen;
        good_mask = 32'hFFFF_FFFF;
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
        wait_wr(4'd9, 1'b0, hit);
        repeat (50) @(negedge clock);
        checks++;
        if (pass_map !== 32'h0000_01FF) begin
            errors++;
            $display("FAIL pre_clr_map: got %h required 000001ff", pass_map);
        end
        clr = 1'b1;
        #1;
        checks++;
        if ({busy, done, found, dly_wr, posneg, best_posneg} !== 6'b0) begin
            errors++;
            $display("FAIL clr_flags: got %b required 000000",
                     {busy, done, found, dly_wr, posneg, best_posneg});
        end
        checks++;
        if ({pass_map, dly_val, best_dly} !== 40'h0) begin
            errors++;
            $display("FAIL clr_vals: map,dly,best got %h required 0", {pass_map, dly_val, best_dly});
        end
        @(negedge clock) clr = 1'b0;
        first_seen = 1'b0;
        fork
            do_scan(cyc);
            begin
                for (int i = 0; i < 8; i++) begin
                    @(negedge clock);
                    if (dly_wr) begin
                        first_seen = 1'b1;
                        break;
                    end
                end
                checks++;
                if (!first_seen || {posneg, dly_val} !== 5'b0) begin
                    errors++;
                    $display("FAIL restart_first: seen %b posneg,dly %b required 1 0_0000",
                             first_seen, {posneg, dly_val});
                end
                repeat (1000) @(negedge clock);
                start = 1'b1;
                repeat (3) @(negedge clock);
                start = 1'b0;
            end
        join
        checks++;
        if (cyc !== ScanCycles) begin
            errors++;
            $display("FAIL start_ignored: got %0d cycles required %0d", cyc, ScanCycles);
        end
        checks++;
        if ({pass_map, found, best_posneg, best_dly} !== {32'hFFFF_FFFF, 1'b1, 1'b0, 4'd7}) begin
            errors++;
            $display("FAIL restart_result: map %h f,pn,dly %b required ffffffff 1_0_0111",
                     pass_map, {found, best_posneg, best_dly});
        end
    endtask

    initial begin
        test_reset();
        test_all_pass();
        test_posneg1_window();
        test_tie();
        test_no_match();
        test_single_error_and_busy();
        test_clr_mid_scan();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alct_rx_phase_scan.md
# alct_rx_phase_scan

Receive-phase calibration controller for the ALCT 80 MHz DDR demultiplexer. It sweeps every combination of inter-stage clock select (`posneg`) and input delay tap, and for each one compares the demux outputs against a known ALCT test pattern. It records a pass/fail map, picks the centre of the longest passing window, and programs that setting back into the demux and delay chain. It runs in the 40 MHz main clock domain, alongside the demux and the delay-chain programmer.

## Interface
Parameters:
- `WIDTH`, 16: demux data width.
- `NDLY`, 16: number of delay taps. Power of 2; tap index width `DW = log2(NDLY)`.
- `SETTLE`, 8: idle cycles after a delay change before comparing. Must be ≥ 4.
- `NCMP`, 256: compare cycles per setting.

Ports:
- `clock`  in  1: 40 MHz TMB main clock.
- `clr`  in  1: reset, asynchronous, active-high.
- `start`  in  1: begin a scan. Level-sampled in IDLE and DONE only.
- `dout1st`  in  WIDTH: demux 1st-in-time output.
- `dout2nd`  in  WIDTH: demux 2nd-in-time output.
- `exp1st`  in  WIDTH: expected 1st-in-time pattern. Static during a scan.
- `exp2nd`  in  WIDTH: expected 2nd-in-time pattern. Static during a scan.
- `dly_busy`  in  1: delay programmer busy.
- `dly_val`  out  DW: delay tap to program.
- `dly_wr`  out  1: one-cycle pulse, program `dly_val`.
- `posneg`  out  1: inter-stage clock select, drives the demux.
- `busy`  out  1: scan in progress.
- `done`  out  1: scan complete. Held until next `start` or `clr`.
- `found`  out  1: at least one passing setting exists.
- `pass_map`  out  2*NDLY: bit `posneg*NDLY + tap` is 1 when that setting passed.
- `best_posneg`  out  1: chosen clock select.
- `best_dly`  out  DW: chosen delay tap.

## Operation
- States: IDLE → SET → WAITB → SETTLE → CMP → REC → (SET | EVAL) → APPLY → WAITA → DONE.
- IDLE/DONE with `start`=1 → SET:
  - clear `pass_map`, `done`, `found`;
  - set `posneg`=0, tap=0, `busy`=1.
- SET: drive `dly_val`=tap and `dly_wr`=1 for exactly 1 cycle; `posneg` already driven. → WAITB.
- WAITB: ignore `dly_busy` on the first cycle, then wait for `dly_busy`=0. → SETTLE.
- SETTLE: count `SETTLE` cycles. → CMP. This covers the 2-clock demux latency.
- CMP: for `NCMP` cycles, set a sticky error flag if any bit of `dout1st`≠`exp1st` or `dout2nd`≠`exp2nd`.
- REC: write `pass_map[posneg*NDLY+tap]` = ~error and clear the error flag.
  - tap<NDLY-1 → tap+1, SET.
  - else posneg=0 → posneg=1, tap=0, SET.
  - else → EVAL.
- EVAL: scan `pass_map`, 1 bit per cycle, 2*NDLY cycles: bits 0..NDLY-1 (posneg 0), then NDLY..2*NDLY-1 (posneg 1).
  - Track the longest contiguous run of 1s per half. Runs never span the half boundary; no wrap-around (the delay line is not circular).
  - Choose the half with the longer run; a tie goes to posneg 0.
  - `best_dly` = run_start + ((run_len-1)>>1), i.e. floor centre.
  - Run lengths are DW+1 bits wide, since a run can be NDLY long.
- No passing bit: `found`=0, `best_posneg`=0, `best_dly`=0.
- APPLY: drive `posneg`=`best_posneg`, `dly_val`=`best_dly`, `dly_wr` pulse. → WAITA, which uses the same handshake as WAITB. → DONE: `busy`=0, `done`=1.
- `start` outside IDLE/DONE is ignored.
- `clr` asserted at any time (including mid-scan or mid-handshake):
  - immediately return to IDLE;
  - zero all outputs and counters;
  - `dly_wr` deasserts asynchronously.

## Timing
- Reset values: every output is 0.
- `busy` rises the cycle after `start` is sampled. `done` rises the same cycle `busy` falls.
- Cycles per setting with zero-wait `dly_busy`: 1 (SET) + 2 (WAITB) + `SETTLE` + `NCMP` + 1 (REC). Default = 268.
- Total with defaults: 32×268 + 32 (EVAL) + 1 (APPLY) + 2 (WAITA) + 1 = 8612 cycles.
- `dly_busy` held high extends WAITB/WAITA indefinitely; there is no timeout.
- `pass_map` bits update in REC and are stable from then on. `best_*`/`found` are valid when `done`=1.

## Structure
- Package `alct_phase_pkg` holds:
  - state enumeration constants;
  - default `NDLY`/`SETTLE`/`NCMP`;
  - a helper to compute DW from NDLY.
- Sub-module `alct_run_finder`: serial longest-run/centre evaluator. Takes a bit stream plus segment-restart strobe, returns best start, length and segment. Used by EVAL.
- The top level contains the FSM, counters, compare logic and handshake.

## Test plan
- All settings pass (demux model always matches) → `pass_map`=all 1s, `found`=1, `best_posneg`=0, `best_dly`=7.
- Pattern matches only for posneg 1, taps 3..10 → `best_posneg`=1, `best_dly`=6, `pass_map`=0x07F8_0000.
- Equal runs: posneg 0 taps 2..5, posneg 1 taps 9..12 → tie resolves to `best_posneg`=0, `best_dly`=3.
- No match anywhere → `found`=0, `best_dly`=0, `best_posneg`=0, `done`=1, final `dly_wr` issued with 0.
- Single-bit error in one CMP cycle at tap 4, posneg 0 (otherwise all pass) → `pass_map` bit 4 = 0; best is posneg 1, tap 7. Also: `dly_busy` held 20 cycles → scan is exactly 20 cycles longer.
- `clr` pulsed mid-CMP at tap 9 → all outputs 0 next cycle. A new `start` reruns from tap 0 / posneg 0, and a `start` during `busy` has no effect.
